// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer for the 8-bit CPU.
// Walks the program memory one byte per cycle and assembles 1- or 2-byte
// instructions into an output register. Taken branches from execute redirect
// the fetch stream.
//
// Handshake (instr_*): a transfer happens on a rising edge where
// instr_valid && instr_ready. While instr_valid && !instr_ready the output
// register is held stable. instr_valid only drops after a transfer, or on a
// redirect or reset.
module instr_fetch_unit #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_op,
    output logic [7:0]        instr_imm,
    output logic              instr_two_byte,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fetch_busy
);

    localparam logic FETCH_OP  = 1'b0;
    localparam logic FETCH_IMM = 1'b1;
    localparam logic [ADDR_W-1:0] PC_STEP = 1;

    logic              state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        op_hold;
    logic [ADDR_W-1:0] op_pc;
    logic              out_free;
    logic              byte_is_two;

    // Program memory is addressed straight from the pc register.
    assign mem_addr   = pc;
    assign fetch_busy = (state == FETCH_IMM);

    // Output register can take a new instruction when empty or being consumed.
    assign out_free = !instr_valid || instr_ready;

    // Length decode: MOV_IMM/CMP_IMM (1000xxxx) and BRA/BHI/BEQ (101xxxxx) carry an immediate.
    assign byte_is_two = (mem_data[7:4] == 4'b1000) || (mem_data[7:5] == 3'b101);

    // Fetch sequencer: pc, state, partial opcode and the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            state          <= FETCH_OP;
            op_hold        <= 8'h00;
            op_pc          <= '0;
            instr_valid    <= 1'b0;
            instr_op       <= 8'h00;
            instr_imm      <= 8'h00;
            instr_two_byte <= 1'b0;
            instr_pc       <= '0;
        end else if (redirect_valid) begin
            // Discard any partial instruction; no byte is consumed this cycle.
            pc          <= redirect_pc;
            state       <= FETCH_OP;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH_OP: begin
                    if (fetch_en && out_free) begin
                        pc <= pc + PC_STEP;
                        if (byte_is_two) begin
                            op_hold     <= mem_data;
                            op_pc       <= pc;
                            state       <= FETCH_IMM;
                            // Anything still valid is being consumed this edge.
                            instr_valid <= 1'b0;
                        end else begin
                            instr_valid    <= 1'b1;
                            instr_op       <= mem_data;
                            instr_imm      <= 8'h00;
                            instr_two_byte <= 1'b0;
                            instr_pc       <= pc;
                        end
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    // Immediate byte: always completes, output register is empty here.
                    pc             <= pc + PC_STEP;
                    state          <= FETCH_OP;
                    instr_valid    <= 1'b1;
                    instr_op       <= op_hold;
                    instr_imm      <= mem_data;
                    instr_two_byte <= 1'b1;
                    instr_pc       <= op_pc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a ROM model and an expected-instruction queue.
module tb_instr_fetch_unit;

    logic       clk;
    logic       reset;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       fetch_en;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_op;
    logic [7:0] instr_imm;
    logic       instr_two_byte;
    logic [7:0] instr_pc;
    logic       fetch_busy;

    logic [7:0]  rom [256];
    logic [24:0] exp_q [$];
    int          n_vec;
    int          n_err;

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_op       (instr_op),
        .instr_imm      (instr_imm),
        .instr_two_byte (instr_two_byte),
        .instr_pc       (instr_pc),
        .fetch_busy     (fetch_busy)
    );

    assign mem_data = rom[mem_addr];

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference length decode, written from the opcode map.
    function automatic logic ref_two(input logic [7:0] b);
        return (b >= 8'h80 && b <= 8'h8F) || (b >= 8'hA0 && b <= 8'hBF);
    endfunction

    // Push the instruction the ROM holds at addr onto the expected queue.
    task automatic push_exp(input logic [7:0] addr);
        logic [7:0] op;
        logic [7:0] nxt;
        logic [7:0] imm;
        logic       two;
        op  = rom[addr];
        nxt = addr + 8'h01;
        two = ref_two(op);
        imm = two ? rom[nxt] : 8'h00;
        exp_q.push_back({op, imm, two, addr});
    endtask

    // Compare the presented instruction with the head of the queue.
    task automatic pop_chk();
        logic [24:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("sb_op",  {24'd0, instr_op},       {24'd0, e[24:17]});
            chk("sb_imm", {24'd0, instr_imm},      {24'd0, e[16:9]});
            chk("sb_two", {31'd0, instr_two_byte}, {31'd0, e[8]});
            chk("sb_pc",  {24'd0, instr_pc},       {24'd0, e[7:0]});
        end
    endtask

    // One clock: score a transfer if one happens on this edge, then settle past the edge.
    task automatic cycle();
        if (instr_valid && instr_ready) pop_chk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] op,
                           input logic [7:0] imm, input logic two, input logic [7:0] pc);
        chk({tag, "_valid"}, {31'd0, instr_valid},    {31'd0, v});
        chk({tag, "_op"},    {24'd0, instr_op},       {24'd0, op});
        chk({tag, "_imm"},   {24'd0, instr_imm},      {24'd0, imm});
        chk({tag, "_two"},   {31'd0, instr_two_byte}, {31'd0, two});
        chk({tag, "_pc"},    {24'd0, instr_pc},       {24'd0, pc});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h70;
        rom[8'h00] = 8'h81; rom[8'h01] = 8'h00;
        rom[8'h04] = 8'h98; rom[8'h05] = 8'h61; rom[8'h06] = 8'h91;
        rom[8'h09] = 8'hB4; rom[8'h0A] = 8'h55;
        rom[8'h0D] = 8'h23;
        rom[8'hFF] = 8'hA8;

        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 8'h00; instr_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        chk_out("rst", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("rst_addr", {24'd0, mem_addr}, 32'h00);
        chk("rst_busy", {31'd0, fetch_busy}, 32'd0);

        // Two-byte instruction right after reset
        reset = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
        push_exp(8'h00);
        cycle();
        chk("t1_busy", {31'd0, fetch_busy}, 32'd1);
        chk("t1_nv",   {31'd0, instr_valid}, 32'd0);
        cycle();
        chk_out("t1", 1'b1, 8'h81, 8'h00, 1'b1, 8'h00);
        chk("t1_addr", {24'd0, mem_addr}, 32'h02);

        // Redirect to 0x04 while 0x81 is being accepted
        redirect_valid = 1'b1; redirect_pc = 8'h04;
        cycle();
        redirect_valid = 1'b0;
        chk("rd_nv",   {31'd0, instr_valid}, 32'd0);
        chk("rd_addr", {24'd0, mem_addr}, 32'h04);

        // Back-to-back one-byte instructions
        push_exp(8'h04); push_exp(8'h05); push_exp(8'h06);
        cycle();
        chk_out("b2b0", 1'b1, 8'h98, 8'h00, 1'b0, 8'h04);
        cycle();
        chk_out("b2b1", 1'b1, 8'h61, 8'h00, 1'b0, 8'h05);

        // Backpressure for three cycles
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk_out("bp", 1'b1, 8'h61, 8'h00, 1'b0, 8'h05);
            chk("bp_addr", {24'd0, mem_addr}, 32'h06);
        end
        instr_ready = 1'b1;
        cycle();
        chk_out("b2b2", 1'b1, 8'h91, 8'h00, 1'b0, 8'h06);

        // Run up to the two-byte opcode at 0x09, then redirect mid-fetch
        push_exp(8'h07); push_exp(8'h08);
        cycle();
        cycle();
        cycle();
        chk("ri_busy", {31'd0, fetch_busy}, 32'd1);
        chk("ri_nv",   {31'd0, instr_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 8'h0D;
        cycle();
        redirect_valid = 1'b0;
        chk("ri_nv2",  {31'd0, instr_valid}, 32'd0);
        chk("ri_busy2", {31'd0, fetch_busy}, 32'd0);
        chk("ri_addr", {24'd0, mem_addr}, 32'h0D);
        push_exp(8'h0D);
        cycle();
        chk_out("ri_tgt", 1'b1, 8'h23, 8'h00, 1'b0, 8'h0D);

        // Halt: accept the last instruction with fetch disabled
        fetch_en = 1'b0;
        cycle();
        chk("halt_nv",   {31'd0, instr_valid}, 32'd0);
        chk("halt_addr", {24'd0, mem_addr}, 32'h0E);

        // Wrap-around: two-byte opcode at 0xFF, immediate at 0x00
        rom[8'h00] = 8'h1A;
        redirect_valid = 1'b1; redirect_pc = 8'hFF;
        cycle();
        redirect_valid = 1'b0; fetch_en = 1'b1;
        push_exp(8'hFF);
        cycle();
        chk("wr_busy", {31'd0, fetch_busy}, 32'd1);
        // fetch_en dropped during the immediate: instruction still completes
        fetch_en = 1'b0;
        cycle();
        chk_out("wr", 1'b1, 8'hA8, 8'h1A, 1'b1, 8'hFF);
        chk("wr_addr", {24'd0, mem_addr}, 32'h01);
        cycle();
        chk("wr_halt_nv",   {31'd0, instr_valid}, 32'd0);
        chk("wr_halt_addr", {24'd0, mem_addr}, 32'h01);

        // Reset during FETCH_IMM discards the partial instruction
        rom[8'h01] = 8'h85;
        fetch_en = 1'b1;
        cycle();
        chk("ri2_busy", {31'd0, fetch_busy}, 32'd1);
        reset = 1'b1;
        cycle();
        chk_out("rst2", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("rst2_addr", {24'd0, mem_addr}, 32'h00);
        chk("rst2_busy", {31'd0, fetch_busy}, 32'd0);
        reset = 1'b0; fetch_en = 1'b0;
        cycle();
        cycle();
        chk("idle_nv", {31'd0, instr_valid}, 32'd0);
        chk("sb_left", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Overall time bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
